debounce_switch_bank: RTL and testbench

- Parametrised N-channel successor to the single-switch debouncer plus release-toggle logic.
- Per channel:
  - synchronises a raw switch pin;
  - debounces it;
  - emits one-cycle press and release pulses;
  - keeps a toggle state;
  - flags long presses.
- Sits between board switch pins and user logic (LED control, mode selection).
- Replaces hand-instantiated debouncers and edge detectors in top-levels.

---
 rtl/debounce_switch_bank_if.sv | 40 ++++
 rtl/debounce_switch_bank.sv | 141 ++++++++++++++
 tb/tb_debounce_switch_bank.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_switch_bank_if.sv
// Switch-bank bus between raw board pins / user logic and the debouncer.
//   i_Switch      raw asynchronous switch pins (1 = pressed)
//   i_Toggle_Clr  synchronous per-channel clear of o_Toggle
//   o_Level       debounced level
//   o_Press       one-cycle pulse on debounced 0->1
//   o_Release     one-cycle pulse on debounced 1->0
//   o_Toggle      per-channel toggle state
//   o_Long        one-cycle pulse when a press reaches the long-press limit
// master = user side (drives pins/clears), slave = debouncer side.
interface debounce_switch_bank_if #(
    parameter int unsigned NUM_SWITCHES = 4
);
    logic [NUM_SWITCHES-1:0] i_Switch;
    logic [NUM_SWITCHES-1:0] i_Toggle_Clr;
    logic [NUM_SWITCHES-1:0] o_Level;
    logic [NUM_SWITCHES-1:0] o_Press;
    logic [NUM_SWITCHES-1:0] o_Release;
    logic [NUM_SWITCHES-1:0] o_Toggle;
    logic [NUM_SWITCHES-1:0] o_Long;

    modport master (
        output i_Switch,
        output i_Toggle_Clr,
        input  o_Level,
        input  o_Press,
        input  o_Release,
        input  o_Toggle,
        input  o_Long
    );

    modport slave (
        input  i_Switch,
        input  i_Toggle_Clr,
        output o_Level,
        output o_Press,
        output o_Release,
        output o_Toggle,
        output o_Long
    );
endinterface

// File: rtl/debounce_switch_bank.sv
// N-channel switch debouncer with press/release pulses, toggle state and
// long-press detection. Channels are fully independent.
//   i_Clk    system clock
//   i_Rst_L  asynchronous active-low reset; clears every flop
//   sw       debounce_switch_bank_if.slave bus (pins, toggle clears, outputs)
// All outputs on the bus are registered.
module debounce_switch_bank #(
    parameter int unsigned NUM_SWITCHES     = 4,
    parameter int unsigned DEBOUNCE_LIMIT   = 250000,
    parameter int unsigned LONG_PRESS_LIMIT = 25000000,
    parameter int unsigned TOGGLE_ON_PRESS  = 0
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    debounce_switch_bank_if.slave  sw
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_LIMIT);
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_LIMIT + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_LIMIT - 1);
    localparam bit                TOG_PRESS = (TOGGLE_ON_PRESS != 0);

    logic [NUM_SWITCHES-1:0] level_v;
    logic [NUM_SWITCHES-1:0] press_v;
    logic [NUM_SWITCHES-1:0] release_v;
    logic [NUM_SWITCHES-1:0] toggle_v;
    logic [NUM_SWITCHES-1:0] long_v;

    for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_ch
        logic [1:0]        sync_q;
        logic [DB_W-1:0]   db_cnt_q;
        logic [HOLD_W-1:0] hold_q;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              long_seen_q;
        logic              toggle_q;

        logic sync_c;
        logic db_done_c;
        logic rise_c;
        logic fall_c;
        logic long_hit_c;
        logic toggle_evt_c;

        // Qualify level changes and derive per-channel events
        always_comb begin
            sync_c       = 1'b0;
            db_done_c    = 1'b0;
            rise_c       = 1'b0;
            fall_c       = 1'b0;
            long_hit_c   = 1'b0;
            toggle_evt_c = 1'b0;

            sync_c     = sync_q[1];
            // Accept the new level on the last of DEBOUNCE_LIMIT disagreeing cycles
            db_done_c  = (sync_c != level_q) && (db_cnt_q == DB_LAST);
            rise_c     = db_done_c && sync_c;
            fall_c     = db_done_c && !sync_c;
            // Hold counter about to reach the limit while still pressed
            long_hit_c = level_q && (hold_q == HOLD_LAST);

            if (TOG_PRESS) begin
                toggle_evt_c = rise_c;
            end else begin
                // A press that already reported o_Long does not toggle on release
                toggle_evt_c = fall_c && !long_seen_q;
            end
        end

        // Synchroniser, debounce counter, hold counter and registered outputs
        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                sync_q      <= 2'b00;
                db_cnt_q    <= '0;
                hold_q      <= '0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                long_q      <= 1'b0;
                long_seen_q <= 1'b0;
                toggle_q    <= 1'b0;
            end else begin
                sync_q <= {sync_q[0], sw.i_Switch[i]};

                // Any agreement between sync and level restarts the count
                if (sync_c == level_q) begin
                    db_cnt_q <= '0;
                end else if (db_done_c) begin
                    db_cnt_q <= '0;
                    level_q  <= sync_c;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end

                press_q   <= rise_c;
                release_q <= fall_c;

                // Saturating press-duration counter
                if (!level_q) begin
                    hold_q <= '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_q <= hold_q + HOLD_W'(1);
                end

                long_q <= long_hit_c;

                // rise needs level low, long_hit needs level high: never together
                if (rise_c) begin
                    long_seen_q <= 1'b0;
                end else if (long_hit_c) begin
                    long_seen_q <= 1'b1;
                end

                // Clear has priority over a coincident toggle event
                if (sw.i_Toggle_Clr[i]) begin
                    toggle_q <= 1'b0;
                end else if (toggle_evt_c) begin
                    toggle_q <= ~toggle_q;
                end
            end
        end

        assign level_v[i]   = level_q;
        assign press_v[i]   = press_q;
        assign release_v[i] = release_q;
        assign toggle_v[i]  = toggle_q;
        assign long_v[i]    = long_q;
    end

    assign sw.o_Level   = level_v;
    assign sw.o_Press   = press_v;
    assign sw.o_Release = release_v;
    assign sw.o_Toggle  = toggle_v;
    assign sw.o_Long    = long_v;

endmodule

// File: tb/tb_debounce_switch_bank.sv
// Bench for debounce_switch_bank: two instances (release-toggle and
// press-toggle) share the same stimulus and are compared every cycle
// against a window/timestamp reference model.
module tb_debounce_switch_bank;

    localparam int NS       = 2;
    localparam int DL       = 4;
    localparam int LP       = 10;
    localparam int EV_PRESS = 0;
    localparam int EV_REL   = 1;

    logic          i_Clk   = 1'b0;
    logic          i_Rst_L = 1'b0;
    logic [NS-1:0] sw_drv  = '0;
    logic [NS-1:0] clr_drv = '0;

    int checks = 0;
    int errors = 0;

    always #5 i_Clk = ~i_Clk;

    debounce_switch_bank_if #(.NUM_SWITCHES(NS)) bus_r ();
    debounce_switch_bank_if #(.NUM_SWITCHES(NS)) bus_p ();

    assign bus_r.i_Switch     = sw_drv;
    assign bus_r.i_Toggle_Clr = clr_drv;
    assign bus_p.i_Switch     = sw_drv;
    assign bus_p.i_Toggle_Clr = clr_drv;

    debounce_switch_bank #(
        .NUM_SWITCHES(NS), .DEBOUNCE_LIMIT(DL),
        .LONG_PRESS_LIMIT(LP), .TOGGLE_ON_PRESS(0)
    ) dut_rel (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .sw(bus_r.slave)
    );

    debounce_switch_bank #(
        .NUM_SWITCHES(NS), .DEBOUNCE_LIMIT(DL),
        .LONG_PRESS_LIMIT(LP), .TOGGLE_ON_PRESS(1)
    ) dut_prs (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .sw(bus_p.slave)
    );

    // Reference model: pin delay line, window of recent sync samples,
    // press timestamps for long-press timing.
    bit m_pipe0   [NS];
    bit m_pipe1   [NS];
    bit m_win     [NS][DL];
    int m_win_n   [NS];
    bit m_lvl     [NS];
    bit m_press   [NS];
    bit m_rel     [NS];
    bit m_long    [NS];
    bit m_seen    [NS];
    bit m_tog_r   [NS];
    bit m_tog_p   [NS];
    int m_press_at[NS];
    bit m_press_ok[NS];
    int m_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NS; c++) begin
            m_pipe0[c] = 1'b0; m_pipe1[c] = 1'b0; m_win_n[c] = 0;
            for (int j = 0; j < DL; j++) m_win[c][j] = 1'b0;
            m_lvl[c] = 1'b0; m_press[c] = 1'b0; m_rel[c] = 1'b0;
            m_long[c] = 1'b0; m_seen[c] = 1'b0;
            m_tog_r[c] = 1'b0; m_tog_p[c] = 1'b0;
            m_press_at[c] = 0; m_press_ok[c] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [NS-1:0] pin, input logic [NS-1:0] clr);
        m_cyc++;
        for (int c = 0; c < NS; c++) begin
            bit old_lvl, new_lvl, s, all_diff, rise, fall, hit, seen_before;
            old_lvl = m_lvl[c];
            s       = m_pipe1[c];
            new_lvl = old_lvl;
            // Level flips once the last DL sync samples all disagree with it
            for (int j = DL - 1; j > 0; j--) m_win[c][j] = m_win[c][j-1];
            m_win[c][0] = s;
            if (m_win_n[c] < DL) m_win_n[c]++;
            all_diff = (m_win_n[c] == DL);
            for (int j = 0; j < DL; j++) if (m_win[c][j] == old_lvl) all_diff = 1'b0;
            if (all_diff) begin
                new_lvl    = ~old_lvl;
                m_win_n[c] = 0;
            end
            rise = new_lvl && !old_lvl;
            fall = !new_lvl && old_lvl;
            // Long press: still held exactly LP cycles after the press pulse
            hit  = old_lvl && m_press_ok[c] && ((m_cyc - m_press_at[c]) == LP);
            if (rise) begin
                m_press_at[c] = m_cyc;
                m_press_ok[c] = 1'b1;
            end
            seen_before = m_seen[c];
            if (rise) m_seen[c] = 1'b0;
            else if (hit) m_seen[c] = 1'b1;
            if (clr[c]) m_tog_r[c] = 1'b0;
            else if (fall && !seen_before) m_tog_r[c] = ~m_tog_r[c];
            if (clr[c]) m_tog_p[c] = 1'b0;
            else if (rise) m_tog_p[c] = ~m_tog_p[c];
            m_lvl[c]   = new_lvl;
            m_press[c] = rise;
            m_rel[c]   = fall;
            m_long[c]  = hit;
            m_pipe1[c] = m_pipe0[c];
            m_pipe0[c] = pin[c];
        end
    endtask

    task automatic check_all();
        logic [NS-1:0] el, ep, er, elg, etr, etp;
        for (int c = 0; c < NS; c++) begin
            el[c] = m_lvl[c]; ep[c] = m_press[c]; er[c] = m_rel[c];
            elg[c] = m_long[c]; etr[c] = m_tog_r[c]; etp[c] = m_tog_p[c];
        end
        chk("level_r",   32'(bus_r.o_Level),   32'(el));
        chk("press_r",   32'(bus_r.o_Press),   32'(ep));
        chk("release_r", 32'(bus_r.o_Release), 32'(er));
        chk("long_r",    32'(bus_r.o_Long),    32'(elg));
        chk("toggle_r",  32'(bus_r.o_Toggle),  32'(etr));
        chk("level_p",   32'(bus_p.o_Level),   32'(el));
        chk("press_p",   32'(bus_p.o_Press),   32'(ep));
        chk("release_p", 32'(bus_p.o_Release), 32'(er));
        chk("long_p",    32'(bus_p.o_Long),    32'(elg));
        chk("toggle_p",  32'(bus_p.o_Toggle),  32'(etp));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 ns later
    task automatic step(input logic [NS-1:0] pin, input logic [NS-1:0] clr);
        sw_drv  = pin;
        clr_drv = clr;
        @(posedge i_Clk);
        if (i_Rst_L) model_edge(pin, clr);
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic run_until(input logic [NS-1:0] pin, input int ch, input int kind,
                             input int maxn, output int at);
        at = 0;
        for (int k = 1; k <= maxn; k++) begin
            step(pin, '0);
            if ((kind == EV_PRESS) ? bus_r.o_Press[ch] : bus_r.o_Release[ch]) begin
                at = k;
                break;
            end
        end
    endtask

    task automatic async_reset();
        #3 i_Rst_L = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    initial begin
        int at, press_n, long_n, long_at;
        bit exp_tog;
        logic [NS-1:0] pin, clr;
        int rem [NS];

        model_reset();

        // Test 1: switches held through reset, released reset -> press at edge 6
        sw_drv = 2'b11;
        repeat (3) step(2'b11, 2'b00);
        chk("t1_reset_level", 32'(bus_r.o_Level), 32'd0);
        i_Rst_L = 1'b1;
        at = 0;
        for (int k = 1; k <= 8; k++) begin
            step(2'b11, 2'b00);
            if (at == 0 && bus_r.o_Press == 2'b11) at = k;
        end
        chk("t1_press_edge", 32'(at), 32'd6);
        repeat (12) step(2'b00, 2'b00);
        step(2'b00, 2'b11);
        chk("t1_toggle_cleared", 32'(bus_r.o_Toggle), 32'd0);

        // Test 2: clean press and release on channel 0
        run_until(2'b01, 0, EV_PRESS, 10, at);
        chk("t2_press_edge", 32'(at), 32'd6);
        repeat (2) step(2'b01, 2'b00);
        run_until(2'b00, 0, EV_REL, 10, at);
        chk("t2_release_edge", 32'(at), 32'd6);
        chk("t2_toggle0", 32'(bus_r.o_Toggle[0]), 32'd1);
        chk("t2_ch1_level", 32'(bus_r.o_Level[1]), 32'd0);

        // Test 3: bounce 3 high / 1 low x5, then stable high
        press_n = 0;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                step((k < 3) ? 2'b01 : 2'b00, 2'b00);
                press_n += int'(bus_r.o_Press[0]);
            end
        end
        chk("t3_no_level_in_bounce", 32'(bus_r.o_Level[0]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step(2'b01, 2'b00);
            press_n += int'(bus_r.o_Press[0]);
        end
        chk("t3_one_press", 32'(press_n), 32'd1);
        repeat (8) step(2'b00, 2'b00);

        // Test 4: long press on channel 1, no toggle on its release
        run_until(2'b10, 1, EV_PRESS, 10, at);
        chk("t4_press_edge", 32'(at), 32'd6);
        long_n = 0; long_at = 0;
        for (int k = 1; k <= 15; k++) begin
            step(2'b10, 2'b00);
            if (bus_r.o_Long[1]) begin
                long_n++;
                if (long_at == 0) long_at = k;
            end
        end
        chk("t4_long_count", 32'(long_n), 32'd1);
        chk("t4_long_offset", 32'(long_at), 32'd10);
        run_until(2'b00, 1, EV_REL, 10, at);
        chk("t4_release_edge", 32'(at), 32'd6);
        chk("t4_toggle_kept", 32'(bus_r.o_Toggle[1]), 32'd0);
        run_until(2'b10, 1, EV_PRESS, 10, at);
        step(2'b10, 2'b00);
        run_until(2'b00, 1, EV_REL, 10, at);
        chk("t4_short_toggles", 32'(bus_r.o_Toggle[1]), 32'd1);

        // Test 5: press-toggle instance flips on press; clear beats toggle
        exp_tog = ~m_tog_p[0];
        run_until(2'b01, 0, EV_PRESS, 10, at);
        chk("t5_toggle_on_press", 32'(bus_p.o_Toggle[0]), 32'(exp_tog));
        run_until(2'b00, 0, EV_REL, 10, at);
        repeat (5) step(2'b01, 2'b00);
        step(2'b01, 2'b01);
        chk("t5_press_with_clr", 32'(bus_p.o_Press[0]), 32'd1);
        chk("t5_clear_wins", 32'(bus_p.o_Toggle[0]), 32'd0);
        repeat (2) step(2'b01, 2'b00);
        repeat (8) step(2'b00, 2'b00);

        // Test 6: asynchronous reset mid long-press (hold count 7)
        run_until(2'b10, 1, EV_PRESS, 10, at);
        repeat (7) step(2'b10, 2'b00);
        async_reset();
        chk("t6_level_zero", 32'(bus_r.o_Level), 32'd0);
        chk("t6_toggle_zero", 32'(bus_r.o_Toggle), 32'd0);
        repeat (2) step(2'b10, 2'b00);
        i_Rst_L = 1'b1;
        run_until(2'b10, 1, EV_PRESS, 10, at);
        chk("t6_repress_edge", 32'(at), 32'd6);
        long_n = 0;
        step(2'b10, 2'b00);
        long_n += int'(bus_r.o_Long[1]);
        for (int k = 0; k < 12; k++) begin
            step(2'b00, 2'b00);
            long_n += int'(bus_r.o_Long[1]);
        end
        chk("t6_no_long", 32'(long_n), 32'd0);

        // Randomised phase: random hold lengths, occasional clears and one reset
        pin = '0;
        for (int c = 0; c < NS; c++) rem[c] = $urandom_range(1, 22);
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < NS; c++) begin
                if (rem[c] == 0) begin
                    pin[c] = ~pin[c];
                    rem[c] = $urandom_range(1, 22);
                end else begin
                    rem[c]--;
                end
            end
            clr = ($urandom_range(0, 15) == 0) ? NS'($urandom_range(0, 3)) : '0;
            step(pin, clr);
            if (n == 400) begin
                async_reset();
                step(pin, '0);
                i_Rst_L = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
